// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int OS_RATE           = 16;
    localparam int OS_CNT_W          = $clog2(OS_RATE);

    // Oversample counter landmarks inside one bit period.
    localparam logic [OS_CNT_W-1:0] OS_SAMP_A = OS_CNT_W'(7);
    localparam logic [OS_CNT_W-1:0] OS_SAMP_B = OS_CNT_W'(8);
    localparam logic [OS_CNT_W-1:0] OS_DECIDE = OS_CNT_W'(9);
    localparam logic [OS_CNT_W-1:0] OS_LAST   = OS_CNT_W'(OS_RATE - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // 2-of-3 vote used to turn three mid-bit samples into one bit value.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Received-frame handshake bundle. The master (receiver) holds rx_data and the
// flags stable while rx_valid is high; a frame moves on any rising clk edge where
// rx_valid and rx_ready are both high. rx_ready may toggle freely.
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Next values: shift the input through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages, both reset to the line's idle level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority-vote bit sampling, optional
// parity, framing/overrun detection and a valid/ready output holding register.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         os_tick,
    input  logic         rx,
    output logic         busy,
    output rx_state_t    dbg_state,
    uart_rx_os_if.master rx_if
);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t              state_d, state_q;
    logic [OS_CNT_W-1:0]    os_cnt_d, os_cnt_q;
    logic [2:0]             bit_cnt_d, bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_d, shift_q;
    logic [1:0]             samp_d, samp_q;
    logic                   maj_d, maj_q;
    logic                   par_err_d, par_err_q;
    logic                   maj_now;
    logic                   par_exp;
    logic                   deliver;
    logic                   deliver_fe;

    logic [DATA_BITS-1:0]   data_d, data_q;
    logic                   valid_d, valid_q;
    logic                   fe_d, fe_q;
    logic                   pe_d, pe_q;
    logic                   overrun_d, overrun_q;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // Frame FSM: every state/counter/sample change is gated by os_tick.
    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        maj_d      = maj_q;
        par_err_d  = par_err_q;
        deliver    = 1'b0;
        deliver_fe = 1'b0;
        maj_now    = majority3(samp_q[0], samp_q[1], rx_s);
        par_exp    = (^shift_q) ^ (PARITY_ODD != 0);

        if (os_tick) begin
            // Bit-timed states count oversample ticks and grab the mid-bit samples.
            if (state_q != ST_IDLE && state_q != ST_WAIT_HIGH) begin
                os_cnt_d = os_cnt_q + OS_CNT_W'(1);
                if (os_cnt_q == OS_SAMP_A) samp_d[0] = rx_s;
                if (os_cnt_q == OS_SAMP_B) samp_d[1] = rx_s;
                if (os_cnt_q == OS_DECIDE) maj_d     = maj_now;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d   = ST_START;
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        par_err_d = 1'b0;
                    end
                end
                ST_START: begin
                    if (os_cnt_q == OS_DECIDE && maj_now) begin
                        // Start bit did not hold low through mid-bit: a glitch.
                        state_d  = ST_IDLE;
                        os_cnt_d = '0;
                    end else if (os_cnt_q == OS_LAST) begin
                        state_d  = ST_DATA;
                        os_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    if (os_cnt_q == OS_LAST) begin
                        shift_d   = {maj_q, shift_q[DATA_BITS-1:1]};
                        os_cnt_d  = '0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (os_cnt_q == OS_LAST) begin
                        if (maj_q != par_exp) par_err_d = 1'b1;
                        state_d  = ST_STOP;
                        os_cnt_d = '0;
                    end
                end
                ST_STOP: begin
                    // Decide at mid stop bit so a following start edge is not missed.
                    if (os_cnt_q == OS_DECIDE) begin
                        deliver    = 1'b1;
                        deliver_fe = ~maj_now;
                        state_d    = maj_now ? ST_IDLE : ST_WAIT_HIGH;
                        os_cnt_d   = '0;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held break must end before another start bit is accepted.
                    if (rx_s) state_d = ST_IDLE;
                end
                default: begin
                    state_d  = ST_IDLE;
                    os_cnt_d = '0;
                end
            endcase
        end
    end

    // Output holding register: handshake drain, new-frame load or overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        fe_d      = fe_q;
        pe_d      = pe_q;
        overrun_d = overrun_q;

        if (valid_q && rx_if.rx_ready) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (deliver) begin
            if (!valid_q || rx_if.rx_ready) begin
                data_d  = shift_q;
                fe_d    = deliver_fe;
                pe_d    = par_err_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            samp_q    <= '0;
            maj_q     <= 1'b0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            samp_q    <= samp_d;
            maj_q     <= maj_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign dbg_state        = state_q;
    assign rx_if.rx_data    = data_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.frame_err  = fe_q;
    assign rx_if.parity_err = pe_q;
    assign rx_if.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 receiver and an 8E1 receiver share
// clock, reset and os_tick; each has its own serial line and handshake bundle.
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int TICK_CLKS = 4;
    localparam int BIT_CLKS  = TICK_CLKS * 16;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } cap_t;

    logic      clk = 1'b0;
    logic      reset_n;
    logic      os_tick;
    logic      rx;
    logic      rx_p;
    logic      busy, busy_p;
    rx_state_t dbg_state, dbg_state_p;

    int checks = 0;
    int errors = 0;

    cap_t cap_q[$];
    cap_t capp_q[$];

    uart_rx_os_if #(.DATA_BITS(8)) bus ();
    uart_rx_os_if #(.DATA_BITS(8)) bus_p ();

    uart_rx_os #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .os_tick   (os_tick),
        .rx        (rx),
        .busy      (busy),
        .dbg_state (dbg_state),
        .rx_if     (bus)
    );

    uart_rx_os #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk       (clk),
        .reset_n   (reset_n),
        .os_tick   (os_tick),
        .rx        (rx_p),
        .busy      (busy_p),
        .dbg_state (dbg_state_p),
        .rx_if     (bus_p)
    );

    // Clock and oversample tick (one pulse every TICK_CLKS cycles).
    always #5 clk = ~clk;

    initial begin
        os_tick = 1'b0;
        forever begin
            repeat (TICK_CLKS - 1) @(negedge clk);
            os_tick = 1'b1;
            @(negedge clk);
            os_tick = 1'b0;
        end
    end

    // Record every handshake transfer of both receivers.
    always @(negedge clk) begin
        #1;
        if (bus.rx_valid && bus.rx_ready)
            cap_q.push_back({bus.rx_data, bus.frame_err, bus.parity_err});
        if (bus_p.rx_valid && bus_p.rx_ready)
            capp_q.push_back({bus_p.rx_data, bus_p.frame_err, bus_p.parity_err});
    end

    // Drive n bits LSB-first on the selected line, one bit period each.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rx = bits[i];
            else          rx_p = bits[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        rx = 1'b1;
        rx_p = 1'b1;
        bus.rx_ready = 1'b1;
        bus_p.rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h exp 00", bus.rx_data); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe: got %0b exp 0", bus.frame_err); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_pe: got %0b exp 0", bus.parity_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %0b exp 0", bus.overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_basic;
        cap_q.delete();
        send_bits(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
        repeat (8) @(negedge clk);
        checks++; if (cap_q.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d exp 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            checks++; if (cap_q[0].data !== 8'h55) begin errors++; $display("FAIL basic_data: got %0h exp 55", cap_q[0].data); end
            checks++; if (cap_q[0].fe !== 1'b0) begin errors++; $display("FAIL basic_fe: got %0b exp 0", cap_q[0].fe); end
            checks++; if (cap_q[0].pe !== 1'b0) begin errors++; $display("FAIL basic_pe: got %0b exp 0", cap_q[0].pe); end
        end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL basic_ovr: got %0b exp 0", bus.overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %0b exp 0", busy); end
    endtask

    task automatic test_glitch;
        logic seen;
        logic cleared;
        seen = 1'b0;
        cleared = 1'b0;
        cap_q.delete();
        rx = 1'b0;
        for (int i = 0; i < 4 * TICK_CLKS; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        rx = 1'b1;
        // Start-bit reject must land before os_cnt 15 of START could be reached.
        for (int i = 0; i < 10 * TICK_CLKS && !cleared; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            else if (seen) cleared = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL glitch_detect: got %0b exp 1", seen); end
        checks++; if (cleared !== 1'b1) begin errors++; $display("FAIL glitch_busy_clear: got %0b exp 1", cleared); end
        repeat (3 * BIT_CLKS) @(negedge clk);
        checks++; if (cap_q.size() !== 0) begin errors++; $display("FAIL glitch_no_frame: got %0d exp 0", cap_q.size()); end
    endtask

    task automatic test_framing;
        cap_q.delete();
        send_bits(0, {6'b0, 1'b0, 8'hA3, 1'b0}, 10);
        repeat (40 * BIT_CLKS) @(negedge clk);
        checks++; if (cap_q.size() !== 1) begin errors++; $display("FAIL frm_count: got %0d exp 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            checks++; if (cap_q[0].data !== 8'hA3) begin errors++; $display("FAIL frm_data: got %0h exp a3", cap_q[0].data); end
            checks++; if (cap_q[0].fe !== 1'b1) begin errors++; $display("FAIL frm_fe: got %0b exp 1", cap_q[0].fe); end
            checks++; if (cap_q[0].pe !== 1'b0) begin errors++; $display("FAIL frm_pe: got %0b exp 0", cap_q[0].pe); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frm_busy_break: got %0b exp 1", busy); end
        checks++; if (dbg_state !== ST_WAIT_HIGH) begin errors++; $display("FAIL frm_state: got %0d exp %0d", dbg_state, ST_WAIT_HIGH); end
        rx = 1'b1;
        repeat (4 * TICK_CLKS) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frm_busy_release: got %0b exp 0", busy); end
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++; if (cap_q.size() !== 1) begin errors++; $display("FAIL frm_no_extra: got %0d exp 1", cap_q.size()); end
    endtask

    task automatic test_parity;
        capp_q.delete();
        send_bits(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (8) @(negedge clk);
        send_bits(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        repeat (8) @(negedge clk);
        checks++; if (capp_q.size() !== 2) begin errors++; $display("FAIL par_count: got %0d exp 2", capp_q.size()); end
        if (capp_q.size() > 1) begin
            checks++; if (capp_q[0].data !== 8'h07) begin errors++; $display("FAIL par_bad_data: got %0h exp 07", capp_q[0].data); end
            checks++; if (capp_q[0].pe !== 1'b1) begin errors++; $display("FAIL par_bad_pe: got %0b exp 1", capp_q[0].pe); end
            checks++; if (capp_q[0].fe !== 1'b0) begin errors++; $display("FAIL par_bad_fe: got %0b exp 0", capp_q[0].fe); end
            checks++; if (capp_q[1].data !== 8'h07) begin errors++; $display("FAIL par_ok_data: got %0h exp 07", capp_q[1].data); end
            checks++; if (capp_q[1].pe !== 1'b0) begin errors++; $display("FAIL par_ok_pe: got %0b exp 0", capp_q[1].pe); end
        end
        checks++; if (dbg_state_p !== ST_IDLE) begin errors++; $display("FAIL par_state: got %0d exp %0d", dbg_state_p, ST_IDLE); end
    endtask

    task automatic test_back_to_back;
        cap_q.delete();
        bus.rx_ready = 1'b0;
        send_bits(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        send_bits(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
        repeat (8) @(negedge clk);
        checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b exp 1", bus.rx_valid); end
        checks++; if (bus.rx_data !== 8'h11) begin errors++; $display("FAIL b2b_data_held: got %0h exp 11", bus.rx_data); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %0b exp 1", bus.overrun); end
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_clear: got %0b exp 0", bus.rx_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_clear: got %0b exp 0", bus.overrun); end
        checks++; if (cap_q.size() !== 1) begin errors++; $display("FAIL b2b_count: got %0d exp 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            checks++; if (cap_q[0].data !== 8'h11) begin errors++; $display("FAIL b2b_xfer_data: got %0h exp 11", cap_q[0].data); end
        end
        bus.rx_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        cap_q.delete();
        send_bits(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 4);
        checks++; if (dbg_state !== ST_DATA) begin errors++; $display("FAIL rst_mid_state: got %0d exp %0d", dbg_state, ST_DATA); end
        reset_n = 1'b0;
        rx = 1'b1;
        #2;
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %0h exp 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b exp 0", bus.rx_valid); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_mid_fe: got %0b exp 0", bus.frame_err); end
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL rst_mid_pe: got %0b exp 0", bus.parity_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_ovr: got %0b exp 0", bus.overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b exp 0", busy); end
        repeat (6) @(negedge clk);
        reset_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        checks++; if (cap_q.size() !== 0) begin errors++; $display("FAIL rst_mid_dropped: got %0d exp 0", cap_q.size()); end
        send_bits(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
        repeat (8) @(negedge clk);
        checks++; if (cap_q.size() !== 1) begin errors++; $display("FAIL rst_next_count: got %0d exp 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            checks++; if (cap_q[0].data !== 8'hC3) begin errors++; $display("FAIL rst_next_data: got %0h exp c3", cap_q[0].data); end
            checks++; if (cap_q[0].fe !== 1'b0) begin errors++; $display("FAIL rst_next_fe: got %0b exp 0", cap_q[0].fe); end
            checks++; if (cap_q[0].pe !== 1'b0) begin errors++; $display("FAIL rst_next_pe: got %0b exp 0", cap_q[0].pe); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..8.
REQ-002 Parameter PARITY_EN, default 0, meaning 1 = one parity bit follows data.
REQ-003 Parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 os_tick  input  1  one-clk pulse at 16x baud rate.
REQ-007 rx  input  1  asynchronous serial line, idle high.
REQ-008 rx_data  output  DATA_BITS  received word, LSB = first data bit.
REQ-009 rx_valid  output  1  rx_data and flags hold a frame.
REQ-010 rx_ready  input  1  consumer accepts the frame.
REQ-011 frame_err  output  1  stop bit sampled low; qualified by rx_valid.
REQ-012 parity_err  output  1  parity mismatch; qualified by rx_valid; 0 when PARITY_EN=0.
REQ-013 overrun  output  1  sticky: a frame was dropped because rx_valid was pending.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 rx SHALL pass through a two-flop synchronizer (reset value 1) before any use.
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; state and counters advance only on os_tick.
REQ-017 Each bit period SHALL be 16 os_ticks, os_cnt 0..15, restarting at 0 on each state entry.
REQ-018 Bit value SHALL be the 2-of-3 majority of synced rx at os_cnt 7, 8, 9.
REQ-019 IDLE: an os_tick with synced rx=0 SHALL enter START with os_cnt=0.
REQ-020 START: at os_cnt=9, majority 1 SHALL return to IDLE (glitch rejected, no output); otherwise at os_cnt=15 enter DATA.
REQ-021 DATA: the majority SHALL be shifted in LSB-first at os_cnt=15; after DATA_BITS bits enter PARITY if PARITY_EN, else STOP.
REQ-022 PARITY: at os_cnt=15 the sampled bit SHALL be compared with XOR(data) XOR PARITY_ODD; mismatch sets the pending parity_err; enter STOP.
REQ-023 STOP: decision SHALL occur at os_cnt=9 (mid-bit) to allow back-to-back frames; majority 1 -> IDLE, majority 0 -> frame_err pending and WAIT_HIGH.
REQ-024 WAIT_HIGH: SHALL stay until an os_tick sees synced rx=1, then IDLE (break never re-triggers).
REQ-025 At the STOP decision clk edge, if rx_valid=0 or (rx_valid and rx_ready), rx_data/frame_err/parity_err SHALL load and rx_valid SHALL be 1 from the next cycle.
REQ-026 Framing-error frames SHALL still be delivered with frame_err=1.
REQ-027 If rx_valid=1 and rx_ready=0 at the STOP decision, the new frame SHALL be discarded, held frame unchanged, overrun set.
REQ-028 Handshake: transfer when rx_valid and rx_ready in same cycle; rx_valid then clears unless REQ-025 reloads it that cycle.
REQ-029 overrun SHALL clear on the cycle of the next transfer.
REQ-030 Without os_tick, state, counters and samples SHALL hold.

Reset
REQ-031 reset_n low SHALL force state IDLE, counters 0, synchronizer 1, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, overrun 0, busy 0, mid-frame included; partial frames are dropped.

Structure
REQ-032 State enum and default DATA_BITS/OS rate constants SHALL live in shared package uart_pkg.
REQ-033 The synchronizer SHALL be sub-module sync_2ff (clk, reset_n, d, q, reset value parameter).

Verification
REQ-034 8N1 frame 0x55, rx_ready=1 -> one rx_valid pulse, rx_data=0x55, all error flags 0.
REQ-035 rx low for 4 os_ticks then high -> no rx_valid, busy returns to 0 by os_cnt=9 of START.
REQ-036 Frame 0xA3 with stop bit 0, then line held low 40 bit-times -> one frame rx_data=0xA3 frame_err=1, no further frames until rx returns high.
REQ-037 PARITY_EN=1 even, data 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1; parity bit 1 -> parity_err=0.
REQ-038 Back-to-back 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun=1; rx_ready pulse clears rx_valid and overrun.
REQ-039 reset_n low mid-DATA of 0x3C, then frame 0xC3 -> all outputs 0 during reset, next delivery rx_data=0xC3, no errors.
